hash_round_sequencer: RTL and testbench
=======================================

// Module: hash_round_sequencer
// PURPOSE
// - Sequences one 128-bit hash block: latches message state and set_type, iterates an external
//   round datapath ROUNDS times, then applies the per-set final constant addition.
// - Sits between the host-side block interface and the round / final-add datapaths.
// - Drives both datapaths and holds the result until the consumer takes it (valid/ready).
// PARAMETERS
// - ROUNDS  16  round iterations per block; legal range 1..255.
// - CNT_W   8   round counter width; must hold ROUNDS-1.
// PORTS
// - clk             in   1    system clock, rising edge.
// - reset           in   1    asynchronous, active-high; clears all state.
// - in_valid        in   1    block request valid.
// - in_ready        out  1    high only in IDLE.
// - in_block        in   128  initial 128-bit state.
// - in_set_type     in   2    constant-set select, latched at accept.
// - rnd_in          out  128  current state to round datapath (= state_q).
// - rnd_idx         out  CNT_W  current round index.
// - rnd_out         in   128  round datapath result, combinational from rnd_in/rnd_idx.
// - fin_A           out  128  state to final-add datapath (= state_q).
// - fin_set_type    out  2    latched set_type.
// - fin_out         in   128  final-add result (per-half 64-bit add of set constants).
// - out_valid       out  1    result valid; held until out_ready.
// - out_ready       in   1    consumer ready.
// - out_hash        out  128  registered result.
// - busy            out  1    high in ROUND or FINAL.
// BEHAVIOUR
// - Reset values: state IDLE; state_q, result_q and cnt = 0; set_q = 0.
//   Outputs after reset: in_ready=1, out_valid=0, busy=0, out_hash=0.
// - FSM states: IDLE, ROUND, FINAL, DONE.
// - IDLE:
//   - in_valid && in_ready at edge E0 -> state_q<=in_block, set_q<=in_set_type, cnt<=0, ->ROUND.
//   - Otherwise hold.
// - ROUND:
//   - Each edge: state_q<=rnd_out, cnt<=cnt+1.
//   - When cnt==ROUNDS-1 at the edge -> FINAL, cnt<=0.
//   - Exactly ROUNDS updates; rnd_idx steps 0..ROUNDS-1.
// - FINAL: one edge -> result_q<=fin_out, ->DONE.
// - DONE:
//   - out_valid=1; out_hash=result_q, stable while stalled.
//   - out_valid && out_ready -> IDLE.
// - Latency: out_valid rises ROUNDS+1 edges after E0.
//   - No new accept in the DONE->IDLE cycle, since in_ready is low in DONE.
//   - Throughput: one block per ROUNDS+3 cycles with out_ready held high.
// - in_valid while not IDLE: ignored, not queued; in_block/in_set_type are don't-care there.
// - ROUNDS=1: single ROUND cycle, then FINAL.
// - Arithmetic lives in the datapaths; 64-bit wrap-around is theirs. The sequencer never
//   modifies data.
// - reset asserted mid-ROUND/FINAL/DONE: immediate return to IDLE, result discarded, no
//   out_valid pulse.
// CONFIGURATION
// - HASH_SEQ_ABORT_EN defined:
//   - Adds input port abort (1 bit).
//   - abort high at an edge in ROUND or FINAL -> IDLE, cnt<=0, result_q unchanged, no out_valid.
//   - abort ignored in IDLE and DONE; abort has priority over round/final progression.
// - HASH_SEQ_ABORT_EN undefined: no abort port; block always runs to completion.
// TESTING
// - Bench round model is identity (rnd_out=rnd_in); fin model is the per-set constant add.
//   ROUNDS=4 unless noted.
// - Basic: in_block=0, set 0 -> out_hash=128'h22312194FC2BF72C_9F555FA3C84C64C2.
//   - out_valid 5 edges after accept; rnd_idx 0,1,2,3.
// - Wrap: in_block=all-ones, set 3 -> out_hash=128'h2B0199FC2C85B8A9_0EB72DDC81C52CA1.
// - Backpressure: out_ready=0 for 10 cycles -> out_valid and out_hash stable.
//   - in_valid pulses in that window are not accepted (in_ready=0).
//   - out_ready=1 -> IDLE next edge; in_ready=1.
// - Reset mid-op: assert reset during rnd_idx=2 -> same-cycle in_ready=1, busy=0, out_hash=0.
//   - Next block (set 1, block 0) -> 128'h2393B86B6F53B151_963877195940EABD.
// - ROUNDS=1, back-to-back requests with out_ready=1 -> accepts spaced exactly 4 cycles;
//   each result correct.
// - HASH_SEQ_ABORT_EN: abort at rnd_idx=1 -> IDLE next edge, no out_valid.
//   - Prior out_hash retained; next block completes normally.

Source files
------------

// File: rtl/hash_round_sequencer.sv
// Sequences one 128-bit hash block: latch state/set, ROUNDS external round steps, one final-add step, hold result.
// Defining HASH_SEQ_ABORT_EN adds an abort input that cancels a block in progress.
module hash_round_sequencer #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  input  logic [1:0]       in_set_type,
`ifdef HASH_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [127:0]     rnd_in,
  output logic [CNT_W-1:0] rnd_idx,
  input  logic [127:0]     rnd_out,
  output logic [127:0]     fin_A,
  output logic [1:0]       fin_set_type,
  input  logic [127:0]     fin_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_hash,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

  fsm_t             fsm_reg, fsm_next;
  logic [127:0]     state_reg, state_next;
  logic [127:0]     result_reg, result_next;
  logic [1:0]       set_reg, set_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_reg    <= IDLE;
      state_reg  <= '0;
      result_reg <= '0;
      set_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      fsm_reg    <= fsm_next;
      state_reg  <= state_next;
      result_reg <= result_next;
      set_reg    <= set_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    fsm_next    = fsm_reg;
    state_next  = state_reg;
    result_next = result_reg;
    set_next    = set_reg;
    cnt_next    = cnt_reg;
    case (fsm_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = in_block;
          set_next   = in_set_type;
          cnt_next   = '0;
          fsm_next   = ROUND;
        end
      end
      ROUND: begin
        state_next = rnd_out;
        if (cnt_reg == LAST_IDX) begin
          cnt_next = '0;
          fsm_next = FINAL;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FINAL: begin
        result_next = fin_out;
        fsm_next    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
`ifdef HASH_SEQ_ABORT_EN
    // Abort wins over round/final progression; the previously delivered result stays visible.
    if (abort && (fsm_reg == ROUND || fsm_reg == FINAL)) begin
      fsm_next    = IDLE;
      cnt_next    = '0;
      state_next  = state_reg;
      result_next = result_reg;
    end
`endif
  end

  assign in_ready     = (fsm_reg == IDLE);
  assign busy         = (fsm_reg == ROUND) || (fsm_reg == FINAL);
  assign out_valid    = (fsm_reg == DONE);
  assign out_hash     = result_reg;
  assign rnd_in       = state_reg;
  assign rnd_idx      = cnt_reg;
  assign fin_A        = state_reg;
  assign fin_set_type = set_reg;

endmodule

// File: tb/tb_hash_round_sequencer.sv
// Self-checking bench for hash_round_sequencer: ROUNDS=4 instance (a) and ROUNDS=1 instance (b).
// Round datapath is identity; final-add datapath adds per-set 64-bit constants to each half.
module tb_hash_round_sequencer;

  localparam int RA = 4;
  localparam int RB = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         a_in_valid = 1'b0;
  logic         a_in_ready;
  logic [127:0] a_in_block = '0;
  logic [1:0]   a_in_set = '0;
  logic [127:0] a_rnd_in, a_rnd_out, a_fin_A, a_fin_out, a_out_hash;
  logic [7:0]   a_rnd_idx;
  logic [1:0]   a_fin_set;
  logic         a_out_valid;
  logic         a_out_ready = 1'b1;
  logic         a_busy;

  logic         b_in_valid = 1'b0;
  logic         b_in_ready;
  logic [127:0] b_in_block = '0;
  logic [1:0]   b_in_set = '0;
  logic [127:0] b_rnd_in, b_rnd_out, b_fin_A, b_fin_out, b_out_hash;
  logic [7:0]   b_rnd_idx;
  logic [1:0]   b_fin_set;
  logic         b_out_valid;
  logic         b_out_ready = 1'b1;
  logic         b_busy;

`ifdef HASH_SEQ_ABORT_EN
  logic a_abort = 1'b0;
  logic b_abort = 1'b0;
`endif

  // Final-add datapath model: per-half 64-bit add with wrap-around.
  function automatic logic [127:0] fin_add(input logic [127:0] a, input logic [1:0] st);
    logic [63:0] kh, kl;
    case (st)
      2'd0:    begin kh = 64'h22312194FC2BF72C; kl = 64'h9F555FA3C84C64C2; end
      2'd1:    begin kh = 64'h2393B86B6F53B151; kl = 64'h963877195940EABD; end
      2'd2:    begin kh = 64'h96283EE2A88EFFE3; kl = 64'hBE5E1E2553863992; end
      default: begin kh = 64'h2B0199FC2C85B8AA; kl = 64'h0EB72DDC81C52CA2; end
    endcase
    return {a[127:64] + kh, a[63:0] + kl};
  endfunction

  // Reference: ROUNDS identity rounds leave the block unchanged, then the set constants are added.
  function automatic logic [127:0] ref_hash(input logic [127:0] blk, input logic [1:0] st, input int rounds);
    logic [127:0] s;
    s = blk;
    for (int r = 0; r < rounds; r++) s = s;
    return fin_add(s, st);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  assign a_rnd_out = a_rnd_in;
  assign a_fin_out = fin_add(a_fin_A, a_fin_set);
  assign b_rnd_out = b_rnd_in;
  assign b_fin_out = fin_add(b_fin_A, b_fin_set);

  hash_round_sequencer #(.ROUNDS(RA), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_block(a_in_block), .in_set_type(a_in_set),
`ifdef HASH_SEQ_ABORT_EN
    .abort(a_abort),
`endif
    .rnd_in(a_rnd_in), .rnd_idx(a_rnd_idx), .rnd_out(a_rnd_out),
    .fin_A(a_fin_A), .fin_set_type(a_fin_set), .fin_out(a_fin_out),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_hash(a_out_hash), .busy(a_busy)
  );

  hash_round_sequencer #(.ROUNDS(RB), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_block(b_in_block), .in_set_type(b_in_set),
`ifdef HASH_SEQ_ABORT_EN
    .abort(b_abort),
`endif
    .rnd_in(b_rnd_in), .rnd_idx(b_rnd_idx), .rnd_out(b_rnd_out),
    .fin_A(b_fin_A), .fin_set_type(b_fin_set), .fin_out(b_fin_out),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_hash(b_out_hash), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with instance a idle; returns at the negedge after the accept edge.
  task automatic a_start(input logic [127:0] blk, input logic [1:0] st);
    chk("a_in_ready_before_accept", 128'(a_in_ready), 128'(1));
    a_in_valid = 1'b1;
    a_in_block = blk;
    a_in_set   = st;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_block = rand128();
    a_in_set   = 2'($urandom);
  endtask

  // Walks the block to DONE, checking round indices; lat = edges from accept to out_valid.
  task automatic a_wait_done(input logic [127:0] blk, input logic [1:0] st, output int lat);
    lat = -1;
    for (int k = 0; k < 64; k++) begin
      if (a_out_valid) begin
        lat = k;
        break;
      end
      if (k < RA) begin
        chk("a_rnd_idx", 128'(a_rnd_idx), 128'(k));
        chk("a_rnd_in", a_rnd_in, blk);
        chk("a_busy_round", 128'(a_busy), 128'(1));
      end else if (k == RA) begin
        chk("a_busy_final", 128'(a_busy), 128'(1));
        chk("a_fin_set_type", 128'(a_fin_set), 128'(st));
      end
      @(negedge clk);
    end
    $display("block %h set %0d latency %0d hash %h", blk, st, lat, a_out_hash);
  endtask

  initial begin
    int lat;
    logic [127:0] blk, exp_h, last_h;
    logic [1:0] st;
    int stall;
    logic [127:0] exp_q[$];
    int last_acc, naccept;

    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(a_in_ready), 128'(1));
    chk("rst_out_valid", 128'(a_out_valid), 128'(0));
    chk("rst_busy", 128'(a_busy), 128'(0));
    chk("rst_out_hash", a_out_hash, 128'(0));
    chk("rst_rnd_idx", 128'(a_rnd_idx), 128'(0));
    chk("rst_b_in_ready", 128'(b_in_ready), 128'(1));
    reset = 1'b0;
    @(negedge clk);

    // Basic vector
    a_out_ready = 1'b1;
    a_start(128'(0), 2'd0);
    a_wait_done(128'(0), 2'd0, lat);
    chk("basic_latency", 128'(lat), 128'(RA + 1));
    chk("basic_hash", a_out_hash, 128'h22312194FC2BF72C_9F555FA3C84C64C2);
    @(negedge clk);
    chk("basic_back_idle", 128'(a_in_ready), 128'(1));
    chk("basic_valid_drop", 128'(a_out_valid), 128'(0));

    // Wrap-around vector
    a_start({128{1'b1}}, 2'd3);
    a_wait_done({128{1'b1}}, 2'd3, lat);
    chk("wrap_latency", 128'(lat), 128'(RA + 1));
    chk("wrap_hash", a_out_hash, 128'h2B0199FC2C85B8A9_0EB72DDC81C52CA1);
    @(negedge clk);

    // Backpressure: 10 stalled cycles with stray in_valid pulses
    blk = rand128();
    st = 2'($urandom);
    exp_h = ref_hash(blk, st, RA);
    a_out_ready = 1'b0;
    a_start(blk, st);
    a_wait_done(blk, st, lat);
    chk("bp_latency", 128'(lat), 128'(RA + 1));
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_held", 128'(a_out_valid), 128'(1));
      chk("bp_hash_held", a_out_hash, exp_h);
      chk("bp_in_ready_low", 128'(a_in_ready), 128'(0));
      a_in_valid = 1'($urandom_range(0, 1));
      a_in_block = rand128();
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 128'(a_in_ready), 128'(1));
    chk("bp_release_valid", 128'(a_out_valid), 128'(0));
    chk("bp_no_stray_accept", 128'(a_busy), 128'(0));
    chk("bp_result_kept", a_out_hash, exp_h);

    // Reset asserted mid-ROUND at rnd_idx=2
    a_start(128'(0), 2'd2);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_idx", 128'(a_rnd_idx), 128'(2));
    #1 reset = 1'b1;
    #1;
    chk("midrst_in_ready", 128'(a_in_ready), 128'(1));
    chk("midrst_busy", 128'(a_busy), 128'(0));
    chk("midrst_out_hash", a_out_hash, 128'(0));
    chk("midrst_out_valid", 128'(a_out_valid), 128'(0));
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_stay_idle", 128'(a_busy), 128'(0));
    a_start(128'(0), 2'd1);
    a_wait_done(128'(0), 2'd1, lat);
    chk("midrst_next_latency", 128'(lat), 128'(RA + 1));
    chk("midrst_next_hash", a_out_hash, 128'h2393B86B6F53B151_963877195940EABD);
    @(negedge clk);

    // Randomized blocks with random consumer stalls
    last_h = a_out_hash;
    for (int n = 0; n < 6; n++) begin
      blk = rand128();
      st = 2'($urandom);
      stall = $urandom_range(0, 3);
      exp_h = ref_hash(blk, st, RA);
      a_out_ready = (stall == 0);
      a_start(blk, st);
      a_wait_done(blk, st, lat);
      chk("rnd_latency", 128'(lat), 128'(RA + 1));
      chk("rnd_hash", a_out_hash, exp_h);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("rnd_stall_valid", 128'(a_out_valid), 128'(1));
        chk("rnd_stall_hash", a_out_hash, exp_h);
      end
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("rnd_back_idle", 128'(a_in_ready), 128'(1));
      last_h = exp_h;
    end

`ifdef HASH_SEQ_ABORT_EN
    // Abort at rnd_idx=1
    a_start(rand128(), 2'($urandom));
    @(negedge clk);
    chk("abort_idx", 128'(a_rnd_idx), 128'(1));
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    chk("abort_idle", 128'(a_in_ready), 128'(1));
    chk("abort_busy", 128'(a_busy), 128'(0));
    chk("abort_cnt", 128'(a_rnd_idx), 128'(0));
    for (int i = 0; i < RA + 2; i++) begin
      chk("abort_no_valid", 128'(a_out_valid), 128'(0));
      chk("abort_hash_kept", a_out_hash, last_h);
      @(negedge clk);
    end
    // Abort in DONE is ignored
    blk = rand128();
    st = 2'($urandom);
    exp_h = ref_hash(blk, st, RA);
    a_out_ready = 1'b0;
    a_start(blk, st);
    a_wait_done(blk, st, lat);
    chk("abort_next_latency", 128'(lat), 128'(RA + 1));
    chk("abort_next_hash", a_out_hash, exp_h);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    chk("abort_done_ignored", 128'(a_out_valid), 128'(1));
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("abort_done_release", 128'(a_in_ready), 128'(1));
`endif

    // ROUNDS=1 instance: back-to-back requests, accepts every 4 cycles
    b_out_ready = 1'b1;
    b_in_block = rand128();
    b_in_set = 2'($urandom);
    b_in_valid = 1'b1;
    last_acc = -1;
    naccept = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (b_out_valid) begin
        chk("b_result_expected", 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) begin
          exp_h = exp_q.pop_front();
          chk("b_hash", b_out_hash, exp_h);
          $display("b result hash %h", b_out_hash);
        end
      end
      if (b_in_ready) begin
        if (last_acc >= 0) chk("b_accept_spacing", 128'(cyc - last_acc), 128'(4));
        last_acc = cyc;
        naccept++;
        exp_q.push_back(ref_hash(b_in_block, b_in_set, RB));
        @(posedge clk);
        #1;
        b_in_block = rand128();
        b_in_set = 2'($urandom);
      end
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    chk("b_accept_count", 128'(naccept >= 9), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
